// File: rtl/apb_controller.sv
// AHB-to-APB transfer sequencer: turns each qualified AHB address phase into one
// APB setup+access transfer, stalling the AHB master via hreadyout until it completes.
module apb_controller #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NSEL   = 3
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              valid,
  input  logic [ADDR_W-1:0] haddr,
  input  logic              hwrite,
  input  logic [NSEL-1:0]   tempselx,
  input  logic [DATA_W-1:0] hwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  output logic [NSEL-1:0]   pselx,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] hrdata,
  output logic              hreadyout,
  output logic [1:0]        hresp
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RSETUP  = 3'd1,
    ST_RACCESS = 3'd2,
    ST_WWAIT   = 3'd3,
    ST_WSETUP  = 3'd4,
    ST_WACCESS = 3'd5
  } state_t;

  state_t            state, state_nxt;
  logic [NSEL-1:0]   sel_q, sel_nxt;
  logic [NSEL-1:0]   pselx_nxt;
  logic              penable_nxt, pwrite_nxt, hreadyout_nxt;
  logic [ADDR_W-1:0] paddr_nxt;
  logic [DATA_W-1:0] pwdata_nxt, hrdata_nxt;

  assign hresp = 2'b00;

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state     <= ST_IDLE;
      sel_q     <= '0;
      pselx     <= '0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      hrdata    <= '0;
      hreadyout <= 1'b1;
    end else begin
      state     <= state_nxt;
      sel_q     <= sel_nxt;
      pselx     <= pselx_nxt;
      penable   <= penable_nxt;
      pwrite    <= pwrite_nxt;
      paddr     <= paddr_nxt;
      pwdata    <= pwdata_nxt;
      hrdata    <= hrdata_nxt;
      hreadyout <= hreadyout_nxt;
    end
  end

  // Every output is registered: the comb block computes next values, holding by default.
  always_comb begin
    state_nxt     = state;
    sel_nxt       = sel_q;
    pselx_nxt     = pselx;
    penable_nxt   = penable;
    pwrite_nxt    = pwrite;
    paddr_nxt     = paddr;
    pwdata_nxt    = pwdata;
    hrdata_nxt    = hrdata;
    hreadyout_nxt = hreadyout;
    unique case (state)
      ST_IDLE: begin
        if (valid) begin
          paddr_nxt     = haddr;
          pwrite_nxt    = hwrite;
          hreadyout_nxt = 1'b0;
          if (hwrite) begin
            // Write data arrives a cycle later, so the select is parked until then.
            sel_nxt   = tempselx;
            state_nxt = ST_WWAIT;
          end else begin
            pselx_nxt = tempselx;
            state_nxt = ST_RSETUP;
          end
        end
      end
      ST_RSETUP: begin
        penable_nxt = 1'b1;
        state_nxt   = ST_RACCESS;
      end
      ST_RACCESS: begin
        if (pready) begin
          hrdata_nxt    = prdata;
          pselx_nxt     = '0;
          penable_nxt   = 1'b0;
          hreadyout_nxt = 1'b1;
          state_nxt     = ST_IDLE;
        end
      end
      ST_WWAIT: begin
        pwdata_nxt  = hwdata;
        pselx_nxt   = sel_q;
        penable_nxt = 1'b0;
        state_nxt   = ST_WSETUP;
      end
      ST_WSETUP: begin
        penable_nxt = 1'b1;
        state_nxt   = ST_WACCESS;
      end
      ST_WACCESS: begin
        if (pready) begin
          pselx_nxt     = '0;
          penable_nxt   = 1'b0;
          hreadyout_nxt = 1'b1;
          state_nxt     = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule
